// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronises N_SRC async lines, latches rising
// edges as pending and raises one fixed-priority request at a time to the core.
module ext_irq_ctrl #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic [N_SRC-1:0] pend_clr,
    input  logic             ExtIAck,
    input  logic             ERet,
    output logic             ExtIRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic             irq_busy,
    output logic [N_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic             ext_irq_q, ext_irq_d;
    logic             irq_busy_q, irq_busy_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] ack_clr;
    logic [ID_W-1:0]  winner;

    always_comb begin
        sync1_d  = irq_src;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        rise     = sync2_q & ~prev_q;
        eligible = pending_q & ~irq_mask;

        // Scan from the top so the lowest eligible index is the last to win.
        winner = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (eligible[i-1]) begin
                winner = ID_W'(i - 1);
            end
        end

        state_d  = state_q;
        irq_id_d = irq_id_q;
        ack_clr  = '0;

        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d  = ST_REQ;
                    irq_id_d = winner;
                end
            end
            ST_REQ: begin
                // ERet is deliberately ignored here, even alongside ExtIAck.
                if (ExtIAck) begin
                    state_d = ST_SERVICE;
                    for (int unsigned i = 0; i < N_SRC; i++) begin
                        if (irq_id_q == ID_W'(i)) begin
                            ack_clr[i] = 1'b1;
                        end
                    end
                end
            end
            ST_SERVICE: begin
                if (ERet) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh edge beats both clears in the same cycle.
        pending_d  = (pending_q & ~ack_clr & ~pend_clr) | rise;
        ext_irq_d  = (state_d == ST_REQ);
        irq_busy_d = (state_d == ST_SERVICE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            irq_id_q   <= '0;
            ext_irq_q  <= 1'b0;
            irq_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            irq_id_q   <= irq_id_d;
            ext_irq_q  <= ext_irq_d;
            irq_busy_q <= irq_busy_d;
        end
    end

    assign ExtIRQ   = ext_irq_q;
    assign irq_id   = irq_id_q;
    assign irq_busy = irq_busy_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Scoreboard bench for ext_irq_ctrl: directed scenarios then random traffic,
// each cycle's expected outputs come from a transaction-level reference model.
module tb_ext_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src, irq_mask, pend_clr;
    logic       ExtIAck, ERet;
    logic       ExtIRQ, irq_busy;
    logic [1:0] irq_id;
    logic [3:0] pending;

    ext_irq_ctrl #(.N_SRC(4), .ID_W(2)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .irq_mask(irq_mask),
        .pend_clr(pend_clr), .ExtIAck(ExtIAck), .ERet(ERet), .ExtIRQ(ExtIRQ),
        .irq_id(irq_id), .irq_busy(irq_busy), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       irq;
        logic [1:0] id;
        logic       busy;
        logic [3:0] pend;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: line sample history, pending set, request/service flags.
    logic [3:0] hist[$];
    logic [3:0] m_pending;
    logic       m_req, m_svc;
    logic [1:0] m_id;
    logic [3:0] src_v, mask_v;

    task automatic model_reset();
        hist      = '{4'b0, 4'b0, 4'b0};
        m_pending = '0;
        m_req     = 1'b0;
        m_svc     = 1'b0;
        m_id      = '0;
    endtask

    task automatic model_step(input logic [3:0] src, input logic [3:0] mask,
                              input logic [3:0] clr, input logic ack, input logic eret);
        logic [3:0] set_v, elig, aclr, newp;
        // hist[k] holds the line sample taken k+1 edges ago.
        set_v = hist[1] & ~hist[2];
        hist  = '{src, hist[0], hist[1]};
        elig  = m_pending & ~mask;
        aclr  = (m_req && ack) ? (4'b0001 << m_id) : 4'b0000;
        newp  = (m_pending & ~aclr & ~clr) | set_v;
        if (!m_req && !m_svc) begin
            if (elig != 0) begin
                m_req = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (elig[i]) begin
                        m_id = 2'(i);
                        break;
                    end
                end
            end
        end else if (m_req) begin
            if (ack) begin
                m_req = 1'b0;
                m_svc = 1'b1;
            end
        end else if (eret) begin
            m_svc = 1'b0;
        end
        m_pending = newp;
        sb.push_back('{irq: m_req, id: m_id, busy: m_svc, pend: m_pending});
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per clock, compared away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ExtIRQ",   {3'b0, ExtIRQ},   {3'b0, e.irq});
            chk("irq_id",   {2'b0, irq_id},   {2'b0, e.id});
            chk("irq_busy", {3'b0, irq_busy}, {3'b0, e.busy});
            chk("pending",  pending,          e.pend);
        end
    end

    task automatic step(input logic ack, input logic eret, input logic [3:0] clr);
        irq_src  = src_v;
        irq_mask = mask_v;
        pend_clr = clr;
        ExtIAck  = ack;
        ERet     = eret;
        @(posedge clk);
        model_step(src_v, mask_v, clr, ack, eret);
        @(negedge clk);
        pend_clr = '0;
        ExtIAck  = 1'b0;
        ERet     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0);
    endtask

    initial begin
        reset = 1'b0; src_v = '0; mask_v = '0;
        irq_src = '0; irq_mask = '0; pend_clr = '0; ExtIAck = 1'b0; ERet = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ExtIRQ",  {3'b0, ExtIRQ},   4'b0);
        chk("rst_busy",    {3'b0, irq_busy}, 4'b0);
        chk("rst_pending", pending,          4'b0);
        reset = 1'b1;

        // Single source: request lands four clocks after the line rises.
        src_v = 4'b0100;
        idle(3);
        chk("t1_pend", pending, 4'b0100);
        chk("t1_irq_early", {3'b0, ExtIRQ}, 4'b0);
        idle(1);
        chk("t1_irq", {3'b0, ExtIRQ}, 4'b1);
        chk("t1_id", {2'b0, irq_id}, 4'd2);
        step(1'b1, 1'b0, 4'b0);
        idle(2);
        step(1'b0, 1'b1, 4'b0);
        idle(2);

        // Two simultaneous sources: lowest index first, the other after ERet.
        src_v = 4'b1110;
        idle(4);
        chk("t2_id1", {2'b0, irq_id}, 4'd1);
        step(1'b1, 1'b0, 4'b0);
        idle(1);
        step(1'b0, 1'b1, 4'b0);
        idle(2);
        chk("t2_id3", {2'b0, irq_id}, 4'd3);
        chk("t2_irq", {3'b0, ExtIRQ}, 4'b1);
        step(1'b1, 1'b0, 4'b0);
        step(1'b0, 1'b1, 4'b0);
        src_v = 4'b0000;
        idle(4);

        // Masked source latches but stays quiet until unmasked.
        mask_v = 4'b0001;
        src_v  = 4'b0001;
        idle(6);
        mask_v = 4'b0000;
        idle(2);

        // ExtIAck with ERet in REQ: ERet ignored, then a later ERet returns to IDLE.
        step(1'b1, 1'b1, 4'b0);
        idle(2);
        step(1'b0, 1'b1, 4'b0);
        idle(2);

        // Re-edge of the requested source in the ack cycle keeps it pending.
        src_v = 4'b0101;
        idle(4);
        src_v = 4'b0001; step(1'b0, 1'b0, 4'b0);
        src_v = 4'b0101; step(1'b0, 1'b0, 4'b0);
        idle(1);
        step(1'b1, 1'b0, 4'b0);
        chk("t5_pend2", {3'b0, pending[2]}, 4'b1);
        idle(1);
        step(1'b0, 1'b1, 4'b0);
        idle(2);
        step(1'b1, 1'b0, 4'b0);

        // Async reset mid-SERVICE with a pending bit set.
        src_v = 4'b0100; step(1'b0, 1'b0, 4'b0);
        src_v = 4'b0101; step(1'b0, 1'b0, 4'b0);
        idle(3);
        #2 reset = 1'b0;
        #1;
        chk("t6_irq",     {3'b0, ExtIRQ},   4'b0);
        chk("t6_busy",    {3'b0, irq_busy}, 4'b0);
        chk("t6_pending", pending,          4'b0);
        chk("t6_id",      {2'b0, irq_id},   4'b0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        src_v = 4'b0;
        irq_src = 4'b0;
        reset = 1'b1;
        idle(4);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            logic       a, r;
            logic [3:0] clr;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) src_v[b] = ~src_v[b];
            end
            if ($urandom_range(15) == 0) mask_v = 4'($urandom);
            clr = ($urandom_range(15) == 0) ? 4'($urandom) : 4'b0;
            a   = ($urandom_range(2) == 0);
            r   = ($urandom_range(3) == 0);
            step(a, r, clr);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
